// File: rtl/mem_access_pkg.sv
// mem_access_pkg
//   Shared definitions for the MEM stage: memory-op codes, data-bus lane
//   count, FSM state encoding, and small helpers that classify an op and
//   build store lane encodings. Imported by the interface and both modules.
package mem_access_pkg;

    localparam int MEM_OP_WIDTH  = 4;
    localparam int DBUS_BE_WIDTH = 4;

    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_NONE = 4'd0;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_LB   = 4'd1;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_LBU  = 4'd2;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_LH   = 4'd3;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_LHU  = 4'd4;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_LW   = 4'd5;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_SB   = 4'd6;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_SH   = 4'd7;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_load(input logic [MEM_OP_WIDTH-1:0] op);
        return op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW};
    endfunction

    function automatic logic is_store(input logic [MEM_OP_WIDTH-1:0] op);
        return op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic is_misaligned(input logic [MEM_OP_WIDTH-1:0] op,
                                           input logic [1:0] addr_lo);
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return addr_lo[0];
            MEM_OP_LW, MEM_OP_SW:             return |addr_lo;
            default:                          return 1'b0;
        endcase
    endfunction

    // Little-endian lane enables; loads always fetch the whole word.
    function automatic logic [DBUS_BE_WIDTH-1:0] store_be(input logic [MEM_OP_WIDTH-1:0] op,
                                                          input logic [1:0] addr_lo);
        case (op)
            MEM_OP_SB: return 4'b0001 << addr_lo;
            MEM_OP_SH: return addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    // Replicate the store operand across all lanes so the slave only has
    // to honour the byte enables.
    function automatic logic [31:0] store_wdata(input logic [MEM_OP_WIDTH-1:0] op,
                                                input logic [31:0] wd);
        case (op)
            MEM_OP_SB: return {4{wd[7:0]}};
            MEM_OP_SH: return {2{wd[15:0]}};
            default:   return wd;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if
//   Data-bus interface between the MEM stage (master) and data memory (slave).
//   req/we/addr/be/wdata are driven by the master and held while req=1;
//   rdata is valid during the single-cycle ack pulse.
interface mem_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                                      req;
    logic                                      we;
    logic [ADDR_W-1:0]                         addr;
    logic [mem_access_pkg::DBUS_BE_WIDTH-1:0]  be;
    logic [DATA_W-1:0]                         wdata;
    logic [DATA_W-1:0]                         rdata;
    logic                                      ack;

    modport master (
        output req, we, addr, be, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/mem_access_load_align.sv
// mem_access_load_align
//   Combinational load lane select and extension.
//   load_q   : raw word returned by the bus
//   addr_lo  : byte offset of the access within that word
//   op       : load op code (LB/LBU/LH/LHU/LW; anything else returns load_q)
//   ext_data : lane-selected, sign- or zero-extended result
module mem_access_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0]             load_q,
    input  logic [1:0]              addr_lo,
    input  logic [MEM_OP_WIDTH-1:0] op,
    output logic [31:0]             ext_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = load_q[7:0];
            2'd1:    byte_sel = load_q[15:8];
            2'd2:    byte_sel = load_q[23:16];
            default: byte_sel = load_q[31:24];
        endcase
        // Halfword alignment is already guaranteed, so only addr_lo[1] matters.
        half_sel = addr_lo[1] ? load_q[31:16] : load_q[15:0];

        case (op)
            MEM_OP_LB:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            MEM_OP_LBU: ext_data = {24'd0, byte_sel};
            MEM_OP_LH:  ext_data = {{16{half_sel[15]}}, half_sel};
            MEM_OP_LHU: ext_data = {16'd0, half_sel};
            default:    ext_data = load_q;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access
//   MEM stage of the 5-stage MIPS core, between EX/MEM and mem_wb.
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     mem_op_in             MEM_OP_* code for the instruction in MEM
//     mem_addr_in           effective byte address
//     mem_wdata_in          store operand (rt)
//     w_reg_*_in, hi/lo_in  writeback fields from EX/MEM
//     w_reg_*_out, hi/lo_out, hilo_wen_out  writeback fields to mem_wb
//     stall_req             freeze IF..EX/MEM and bubble mem_wb
//     addr_err              misaligned access flag for the exception unit
//     dbus                  data-bus master (registered request side)
//   A memory op spends one IDLE cycle issuing, one or more BUSY cycles
//   waiting for ack, and one DONE cycle delivering its result. Non-memory
//   ops pass through combinationally with no added latency.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [MEM_OP_WIDTH-1:0] mem_op_in,
    input  logic [ADDR_W-1:0]       mem_addr_in,
    input  logic [DATA_W-1:0]       mem_wdata_in,
    input  logic [4:0]              w_reg_addr_in,
    input  logic [DATA_W-1:0]       w_reg_data_in,
    input  logic                    w_reg_en_in,
    input  logic [DATA_W-1:0]       hi_in,
    input  logic [DATA_W-1:0]       lo_in,
    input  logic                    hilo_wen_in,

    output logic [4:0]              w_reg_addr_out,
    output logic [DATA_W-1:0]       w_reg_data_out,
    output logic                    w_reg_en_out,
    output logic [DATA_W-1:0]       hi_out,
    output logic [DATA_W-1:0]       lo_out,
    output logic                    hilo_wen_out,

    output logic                    stall_req,
    output logic                    addr_err,

    mem_access_if.master            dbus
);

    state_t                   state;
    state_t                   state_nx;

    logic                     is_mem;
    logic                     mem_ok;

    logic                     req_q;
    logic                     we_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [DBUS_BE_WIDTH-1:0] be_q;
    logic [DATA_W-1:0]        wdata_q;
    logic [DATA_W-1:0]        load_q;
    logic [MEM_OP_WIDTH-1:0]  op_q;
    logic [1:0]               addr_lo_q;
    logic [31:0]              ext_data;

    // Op classification shared by the FSM and the output logic.
    always_comb begin
        is_mem   = is_load(mem_op_in) || is_store(mem_op_in);
        addr_err = is_mem && is_misaligned(mem_op_in, mem_addr_in[1:0]);
        mem_ok   = is_mem && !addr_err;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // FSM next-state logic. DONE always falls back to IDLE because the
    // pipeline advances on that same edge and the op leaves MEM.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (mem_ok)   state_nx = ST_BUSY;
            ST_BUSY: if (dbus.ack) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs. Writebacks are suppressed while stalled so the frozen
    // instruction commits exactly once, in DONE.
    always_comb begin
        stall_req      = ((state == ST_IDLE) && mem_ok) || (state == ST_BUSY);
        w_reg_en_out   = w_reg_en_in && !stall_req && !addr_err;
        hilo_wen_out   = hilo_wen_in && !stall_req && !addr_err;
        w_reg_addr_out = w_reg_addr_in;
        hi_out         = hi_in;
        lo_out         = lo_in;
        if ((state == ST_DONE) && is_load(op_q)) w_reg_data_out = ext_data;
        else                                     w_reg_data_out = w_reg_data_in;
    end

    // Bus request registers and captured read data. Request fields are
    // latched once at issue and held untouched through BUSY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            load_q    <= '0;
            op_q      <= MEM_OP_NONE;
            addr_lo_q <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_ok) begin
                        req_q     <= 1'b1;
                        we_q      <= is_store(mem_op_in);
                        addr_q    <= {mem_addr_in[ADDR_W-1:2], 2'b00};
                        be_q      <= store_be(mem_op_in, mem_addr_in[1:0]);
                        wdata_q   <= store_wdata(mem_op_in, mem_wdata_in);
                        op_q      <= mem_op_in;
                        addr_lo_q <= mem_addr_in[1:0];
                    end
                end
                ST_BUSY: begin
                    if (dbus.ack) begin
                        load_q <= dbus.rdata;
                        req_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbus.req   = req_q;
    assign dbus.we    = we_q;
    assign dbus.addr  = addr_q;
    assign dbus.be    = be_q;
    assign dbus.wdata = wdata_q;

    mem_access_load_align u_load_align (
        .load_q   (load_q),
        .addr_lo  (addr_lo_q),
        .op       (op_q),
        .ext_data (ext_data)
    );

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access
//   Randomized and directed stimulus for mem_access with a transaction-level
//   reference model; one compare process checks every cycle.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  mem_op_in;
    logic [31:0] mem_addr_in, mem_wdata_in, w_reg_data_in, hi_in, lo_in;
    logic [4:0]  w_reg_addr_in;
    logic        w_reg_en_in, hilo_wen_in;
    logic [4:0]  w_reg_addr_out;
    logic [31:0] w_reg_data_out, hi_out, lo_out;
    logic        w_reg_en_out, hilo_wen_out, stall_req, addr_err;

    mem_access_if #(.ADDR_W(32), .DATA_W(32)) dbus ();

    mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_op_in      (mem_op_in),
        .mem_addr_in    (mem_addr_in),
        .mem_wdata_in   (mem_wdata_in),
        .w_reg_addr_in  (w_reg_addr_in),
        .w_reg_data_in  (w_reg_data_in),
        .w_reg_en_in    (w_reg_en_in),
        .hi_in          (hi_in),
        .lo_in          (lo_in),
        .hilo_wen_in    (hilo_wen_in),
        .w_reg_addr_out (w_reg_addr_out),
        .w_reg_data_out (w_reg_data_out),
        .w_reg_en_out   (w_reg_en_out),
        .hi_out         (hi_out),
        .lo_out         (lo_out),
        .hilo_wen_out   (hilo_wen_out),
        .stall_req      (stall_req),
        .addr_err       (addr_err),
        .dbus           (dbus.master)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    // ---------------- reference model (from the op semantics) ----------------
    function automatic int op_size(input logic [3:0] op);
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: return 1;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return 2;
            MEM_OP_LW, MEM_OP_SW:             return 4;
            default:                          return 0;
        endcase
    endfunction

    function automatic bit m_is_store(input logic [3:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic bit m_misaligned(input logic [3:0] op, input logic [31:0] a);
        int sz = op_size(op);
        return (sz > 1) && ((a % sz) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
        int     off = int'(a % 4);
        int     sz  = op_size(op);
        longint r   = rd;
        longint v;
        v = (r >> (8 * off)) & ((longint'(1) << (8 * sz)) - 1);
        if ((op == MEM_OP_LB || op == MEM_OP_LH) && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
        logic [3:0] be = 4'h0;
        int off = int'(a % 4);
        int sz  = op_size(op);
        if (!m_is_store(op)) return 4'hF;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] wd);
        logic [31:0] w = '0;
        int sz = op_size(op);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % sz) +: 8];
        return w;
    endfunction

    // ---------------- expectations for the compare process ----------------
    logic        exp_on = 1'b0;
    logic        exp_stall, exp_err, exp_en, exp_hilo, exp_req, exp_bus, exp_we, exp_st;
    logic [31:0] exp_data, exp_addr, exp_wdata;
    logic [3:0]  exp_be;

    always @(negedge clk) begin
        if (exp_on) begin
            chk1("stall_req", stall_req, exp_stall);
            chk1("addr_err", addr_err, exp_err);
            chk1("w_reg_en_out", w_reg_en_out, exp_en);
            chk1("hilo_wen_out", hilo_wen_out, exp_hilo);
            chk("w_reg_data_out", w_reg_data_out, exp_data);
            chk({27'd0, w_reg_addr_out} == {27'd0, w_reg_addr_in} ? "w_reg_addr_out" : "w_reg_addr_out",
                {27'd0, w_reg_addr_out}, {27'd0, w_reg_addr_in});
            chk("hi_out", hi_out, hi_in);
            chk("lo_out", lo_out, lo_in);
            chk1("dbus_req", dbus.req, exp_req);
            if (exp_bus) begin
                chk1("dbus_we", dbus.we, exp_we);
                chk("dbus_addr", dbus.addr, exp_addr);
                chk({28'd0, dbus.be} == 32'd0 ? "dbus_be" : "dbus_be", {28'd0, dbus.be}, {28'd0, exp_be});
                if (exp_st) chk("dbus_wdata", dbus.wdata, exp_wdata);
            end
        end
    end

    // ---------------- driver ----------------
    int          obs_stall, obs_wb;
    logic [31:0] obs_data, obs_addr, obs_wd;
    logic [3:0]  obs_be;
    logic        obs_we, obs_err;

    task automatic cycle();
        @(negedge clk);
        if (stall_req) obs_stall++;
        if (addr_err)  obs_err = 1'b1;
        if (w_reg_en_out) begin obs_wb++; obs_data = w_reg_data_out; end
        if (dbus.req) begin
            obs_addr = dbus.addr; obs_be = dbus.be; obs_we = dbus.we; obs_wd = dbus.wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int delay, input logic en);
        bit err, mem;
        obs_stall = 0; obs_wb = 0; obs_data = '0; obs_err = 1'b0;
        obs_addr = '0; obs_be = '0; obs_we = 1'b0; obs_wd = '0;
        mem_op_in = op; mem_addr_in = a; mem_wdata_in = wd;
        w_reg_addr_in = 5'($urandom); w_reg_data_in = $urandom; w_reg_en_in = en;
        hi_in = $urandom; lo_in = $urandom; hilo_wen_in = 1'($urandom);
        err = m_misaligned(op, a);
        mem = op_size(op) > 0;
        exp_addr = {a[31:2], 2'b00}; exp_be = m_be(op, a);
        exp_we = m_is_store(op); exp_st = m_is_store(op); exp_wdata = m_wdata(op, wd);
        exp_data = w_reg_data_in;
        if (mem && !err) begin
            exp_stall = 1; exp_err = 0; exp_en = 0; exp_hilo = 0; exp_req = 0; exp_bus = 0;
            cycle();
            exp_req = 1; exp_bus = 1;
            for (int k = 1; k <= delay; k++) begin
                dbus.ack   = (k == delay);
                dbus.rdata = (k == delay) ? rd : $urandom;
                cycle();
            end
            dbus.ack = 1'b0; dbus.rdata = $urandom;
            exp_stall = 0; exp_req = 0; exp_bus = 0;
            exp_en = en; exp_hilo = hilo_wen_in;
            if (!m_is_store(op)) exp_data = m_load(op, a, rd);
            cycle();
        end else begin
            exp_stall = 0; exp_err = err; exp_req = 0; exp_bus = 0;
            exp_en = en && !err; exp_hilo = hilo_wen_in && !err;
            cycle();
        end
    endtask

    initial begin
        mem_op_in = MEM_OP_NONE; mem_addr_in = '0; mem_wdata_in = '0;
        w_reg_addr_in = '0; w_reg_data_in = '0; w_reg_en_in = 1'b0;
        hi_in = '0; lo_in = '0; hilo_wen_in = 1'b0;
        dbus.ack = 1'b0; dbus.rdata = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk1("rst_req", dbus.req, 1'b0);
        chk1("rst_we", dbus.we, 1'b0);
        chk("rst_addr", dbus.addr, 32'h0);
        chk({28'd0, dbus.be} == 32'd0 ? "rst_be" : "rst_be", {28'd0, dbus.be}, 32'h0);
        chk("rst_wdata", dbus.wdata, 32'h0);
        chk1("rst_stall", stall_req, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_on = 1'b1;

        // Word load, single wait cycle.
        do_op(MEM_OP_LW, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1'b1);
        chk("lw_stall_cycles", obs_stall, 2);
        chk("lw_wb_count", obs_wb, 1);
        chk("lw_data", obs_data, 32'hDEADBEEF);
        chk("lw_addr", obs_addr, 32'h100);
        chk("lw_be", {28'd0, obs_be}, 32'hF);

        // Sub-word loads.
        do_op(MEM_OP_LB, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b1);
        chk("lb_data", obs_data, 32'hFFFFFF80);
        do_op(MEM_OP_LBU, 32'h103, 32'h0, 32'h80FF0000, 2, 1'b1);
        chk("lbu_data", obs_data, 32'h00000080);
        do_op(MEM_OP_LH, 32'h102, 32'h0, 32'h80FF0000, 1, 1'b1);
        chk("lh_data", obs_data, 32'hFFFF80FF);

        // Stores.
        do_op(MEM_OP_SB, 32'h201, 32'h000000AB, 32'h0, 1, 1'b0);
        chk("sb_be", {28'd0, obs_be}, 32'h2);
        chk("sb_wdata", obs_wd, 32'hABABABAB);
        chk1("sb_we", obs_we, 1'b1);
        do_op(MEM_OP_SH, 32'h202, 32'h00001234, 32'h0, 1, 1'b0);
        chk("sh_be", {28'd0, obs_be}, 32'hC);
        chk("sh_wdata", obs_wd, 32'h12341234);

        // Misaligned word load.
        do_op(MEM_OP_LW, 32'h102, 32'h0, 32'h0, 1, 1'b1);
        chk1("err_flag", obs_err, 1'b1);
        chk("err_stall", obs_stall, 0);
        chk("err_wb", obs_wb, 0);

        // Long wait.
        do_op(MEM_OP_LW, 32'h400, 32'h0, 32'h13579BDF, 5, 1'b1);
        chk("slow_stall_cycles", obs_stall, 6);
        chk("slow_wb_count", obs_wb, 1);
        chk("slow_data", obs_data, 32'h13579BDF);

        // Non-memory op: zero latency.
        do_op(MEM_OP_NONE, 32'h0, 32'h0, 32'h0, 1, 1'b1);
        chk("none_stall", obs_stall, 0);
        chk("none_wb", obs_wb, 1);

        // Reset while BUSY, then a stray ack.
        exp_on = 1'b0;
        mem_op_in = MEM_OP_LW; mem_addr_in = 32'h300; w_reg_en_in = 1'b1; hilo_wen_in = 1'b0;
        dbus.ack = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_op_in = MEM_OP_NONE; w_reg_data_in = 32'h55;
        @(negedge clk);
        chk1("rstbusy_req", dbus.req, 1'b0);
        chk1("rstbusy_stall", stall_req, 1'b0);
        chk1("rstbusy_en", w_reg_en_out, 1'b1);
        chk("rstbusy_data", w_reg_data_out, 32'h55);
        @(posedge clk);
        #1;
        dbus.ack = 1'b1; dbus.rdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        dbus.ack = 1'b0;
        @(negedge clk);
        chk1("lateack_req", dbus.req, 1'b0);
        chk1("lateack_stall", stall_req, 1'b0);
        chk("lateack_data", w_reg_data_out, 32'h55);
        @(posedge clk);
        #1;
        exp_on = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            logic [3:0]  op;
            logic [31:0] a;
            op = 4'($urandom_range(0, 8));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (op_size(op) == 2) a[0] = 1'b0;
                if (op_size(op) == 4) a[1:0] = 2'b00;
            end
            do_op(op, a, $urandom, $urandom, $urandom_range(1, 4), 1'($urandom));
        end

        exp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
